decoder_2to4_strobe: RTL and testbench
======================================

// Module: decoder_2to4_strobe
// PURPOSE
//  - Receive end of the 2-bit code path: takes 2-bit codes of the form the 4-to-2 encoder
//    produces and turns them back into timed one-hot strobes.
//  - Codes are accepted through a valid/ready handshake and buffered in a small FIFO.
//  - Codes are replayed in order. Each one drives its one-hot line for HOLD cycles, then
//    all lines go low for GAP cycles.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of 2, >= 2
//  HOLD   2  cycles each one-hot strobe is held; >= 1
//  GAP    1  idle cycles (out=0) after each strobe; >= 0
// PORTS
//  clk       in   1                  clock, rising edge
//  rst       in   1                  synchronous reset, active high
//  in        in   2                  code to decode
//  in_valid  in   1                  in is valid this cycle
//  in_ready  out  1                  FIFO can accept (= !full)
//  out       out  4                  one-hot strobe; 4'b0000 when idle/gap
//  out_valid out  1                  high exactly when out != 0
//  busy      out  1                  FSM not in IDLE, or FIFO non-empty
//  count     out  $clog2(DEPTH)+1    FIFO fill level, 0..DEPTH
//  overflow  out  1                  only with DEC_OVERFLOW_FLAG_EN; see CONFIGURATION
// BEHAVIOUR
//  - One clock, clk. Reset rst is synchronous and active high. All state is registered.
//  - Reset values: out=0, out_valid=0, busy=0, count=0, in_ready=1, overflow=0.
//    Reset also empties the FIFO and puts the FSM in IDLE.
//  - Push: on an edge where in_valid && in_ready, in is written at the write pointer and count
//    increments. When full, in_valid is ignored, including on the same edge as a pop.
//    in_ready is a function of registered count only.
//  - Pop: the FSM reads the head entry and count decrements. Push and pop on the same edge
//    leave count unchanged.
//  - Pointers: log2(DEPTH) bits, natural wrap-around. The full/empty decision uses count.
//  - Decode: out <= 4'b0001 << code.
//  - FSM states: IDLE, DRIVE, GAP. A down-counter, wide enough for max(HOLD,GAP), times
//    DRIVE and GAP.
//   IDLE : stays while count==0.
//          If count!=0, pops the head, loads out, counter<=HOLD-1, goes to DRIVE.
//   DRIVE: out is held.
//          While counter!=0, counter decrements.
//          When counter==0 and GAP>0: out<=0, counter<=GAP-1, goes to GAP.
//          When counter==0 and GAP==0 and count!=0: pops the next code straight into DRIVE
//          (strobes back to back, no zero cycle).
//          When counter==0 and GAP==0 and count==0: out<=0, goes to IDLE.
//   GAP  : out=0.
//          While counter!=0, counter decrements.
//          When counter==0 and count!=0: pops the next code into DRIVE.
//          When counter==0 and count==0: goes to IDLE.
//  - Latency: accept on edge E0; FSM pops on E1; out is one-hot from E1 for HOLD cycles.
//    There is no bypass around the FIFO, so a push into an empty FIFO still has 2-edge latency.
//  - The FSM tests registered count. A code pushed on the last GAP edge is popped on the
//    next edge, via IDLE.
//  - Reset mid-strobe: out=0 after the reset edge. Queued codes are discarded and never emitted.
//  - busy = (state!=IDLE) || (count!=0).
// CONFIGURATION
//  Macro DEC_OVERFLOW_FLAG_EN
//   - Defined: adds port overflow, a sticky flag. It is set on any edge where
//     in_valid && !in_ready. It is cleared only by rst.
//   - Undefined: the port and its logic are absent, and dropped pushes are silent.
//   - Core behaviour is identical either way.
// TESTING
//  Use defaults DEPTH=4, HOLD=2, GAP=1 unless a scenario states otherwise.
//  1. Reset: hold rst 2 cycles -> out=0, out_valid=0, busy=0, count=0, in_ready=1.
//  2. Push in=2'b10 once -> out=4'b0100 for exactly 2 cycles starting 2 edges after
//     acceptance, then out=0 for 1 cycle, then IDLE with busy=0.
//  3. Push 0,1,2,3 back to back -> out sequence 0001,0001,0000,0010,0010,0000,0100,
//     0100,0000,1000,1000,0000. Order preserved and count never exceeds 4.
//  4. With GAP=0, push 3,0 -> out sequence 1000,1000,0001,0001, then 0. No zero cycle
//     between the two strobes.
//  5. Fill the FIFO while out is held on a long strobe (HOLD=8) -> count=4, in_ready=0.
//     A fifth push is dropped. With DEC_OVERFLOW_FLAG_EN, overflow=1 and stays 1 until rst.
//  6. Assert rst during the 2nd cycle of a strobe with 3 codes queued -> out=0 after the
//     edge, count=0, no further strobes.

Source files
------------

// File: rtl/decoder_2to4_strobe.sv
// Buffers 2-bit codes in a small FIFO and replays each one as a one-hot strobe of HOLD cycles, followed by GAP idle cycles.
// Optional sticky overflow flag for dropped pushes when DEC_OVERFLOW_FLAG_EN is defined.
module decoder_2to4_strobe #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 2,
  parameter int unsigned GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [3:0]               out,
  output logic                     out_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
`ifdef DEC_OVERFLOW_FLAG_EN
  ,
  output logic                     overflow
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned TMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic [3:0]    out_nxt;
  logic          pop;
  logic          push;
  logic          has_code;

  assign in_ready = (count != CNTW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign has_code = (count != '0);
  assign busy     = (state != S_IDLE) || has_code;

  // Strobe sequencer: decides pops, the next strobe value and the dwell timer.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    out_nxt   = out;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (has_code) begin
          pop       = 1'b1;
          out_nxt   = 4'(1) << mem[rd_ptr];
          timer_nxt = TW'(HOLD - 1);
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else if (GAP != 0) begin
          out_nxt   = 4'b0000;
          timer_nxt = TW'(GAP - 1);
          state_nxt = S_GAP;
        end else if (has_code) begin
          // No gap configured: chain the next strobe with no zero cycle.
          pop       = 1'b1;
          out_nxt   = 4'(1) << mem[rd_ptr];
          timer_nxt = TW'(HOLD - 1);
        end else begin
          out_nxt   = 4'b0000;
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else if (has_code) begin
          pop       = 1'b1;
          out_nxt   = 4'(1) << mem[rd_ptr];
          timer_nxt = TW'(HOLD - 1);
          state_nxt = S_DRIVE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, strobe output and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      out       <= 4'b0000;
      out_valid <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      out       <= out_nxt;
      out_valid <= (out_nxt != 4'b0000);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in;
  end

`ifdef DEC_OVERFLOW_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_2to4_strobe.sv
// Bench for decoder_2to4_strobe: three instances (default, GAP=0, HOLD=8) share one input stream
// and are compared with a timeline model of strobe start times.
module tb_decoder_2to4_strobe;

  localparam int NI    = 3;
  localparam int DEPTH = 4;
  localparam int HOLD_K [NI] = '{2, 2, 8};
  localparam int GAP_K  [NI] = '{1, 0, 1};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    code = 2'b00;
  logic          in_valid = 1'b0;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] busy;
  logic [NI-1:0] ovf;
  logic [3:0]    out   [NI];
  logic [2:0]    count [NI];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decoder_2to4_strobe #(.DEPTH(4), .HOLD(2), .GAP(1)) u_def (
    .clk(clk), .rst(rst), .in(code), .in_valid(in_valid), .in_ready(in_ready[0]),
    .out(out[0]), .out_valid(out_valid[0]), .busy(busy[0]), .count(count[0])
`ifdef DEC_OVERFLOW_FLAG_EN
    , .overflow(ovf[0])
`endif
  );

  decoder_2to4_strobe #(.DEPTH(4), .HOLD(2), .GAP(0)) u_gap0 (
    .clk(clk), .rst(rst), .in(code), .in_valid(in_valid), .in_ready(in_ready[1]),
    .out(out[1]), .out_valid(out_valid[1]), .busy(busy[1]), .count(count[1])
`ifdef DEC_OVERFLOW_FLAG_EN
    , .overflow(ovf[1])
`endif
  );

  decoder_2to4_strobe #(.DEPTH(4), .HOLD(8), .GAP(1)) u_hold8 (
    .clk(clk), .rst(rst), .in(code), .in_valid(in_valid), .in_ready(in_ready[2]),
    .out(out[2]), .out_valid(out_valid[2]), .busy(busy[2]), .count(count[2])
`ifdef DEC_OVERFLOW_FLAG_EN
    , .overflow(ovf[2])
`endif
  );

`ifndef DEC_OVERFLOW_FLAG_EN
  assign ovf = '0;
`endif

  // Reference model: each code starts its strobe at the first edge where it is queued and the
  // previous strobe+gap window has elapsed; the strobe lasts HOLD edges.
  int         t = 0;
  int         pre;
  int         m_cnt   [NI] = '{0, 0, 0};
  int         m_head  [NI] = '{0, 0, 0};
  int         m_free  [NI] = '{0, 0, 0};
  int         m_start [NI] = '{0, 0, 0};
  bit         m_have  [NI] = '{0, 0, 0};
  bit         m_ovf   [NI] = '{0, 0, 0};
  logic [1:0] m_code  [NI];
  logic [1:0] m_q     [NI][8];

  always @(posedge clk) begin
    t = t + 1;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_cnt[k]  = 0;
        m_head[k] = 0;
        m_have[k] = 0;
        m_free[k] = t;
        m_ovf[k]  = 0;
      end else begin
        pre = m_cnt[k];
        if (m_cnt[k] > 0 && m_free[k] <= t) begin
          m_have[k]  = 1;
          m_code[k]  = m_q[k][m_head[k]];
          m_start[k] = t;
          m_free[k]  = t + HOLD_K[k] + GAP_K[k];
          m_head[k]  = (m_head[k] + 1) % 8;
          m_cnt[k]   = m_cnt[k] - 1;
        end
        if (in_valid) begin
          if (pre < DEPTH) begin
            m_q[k][(m_head[k] + m_cnt[k]) % 8] = code;
            m_cnt[k] = m_cnt[k] + 1;
          end else begin
            m_ovf[k] = 1;
          end
        end
      end
    end
  end

  function automatic logic [3:0] m_out(input int k);
    if (m_have[k] && (t - m_start[k]) < HOLD_K[k]) return 4'(2 ** m_code[k]);
    return 4'b0000;
  endfunction

  function automatic logic m_busy(input int k);
    return (t < m_free[k]) || (m_cnt[k] != 0);
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [1:0] c);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    code     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_reset;
    cyc(1'b1, 1'b0, 2'b00);
    cyc(1'b1, 1'b0, 2'b00);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({out[k], out_valid[k], busy[k], count[k], in_ready[k]} !== {4'b0000, 1'b0, 1'b0, 3'd0, 1'b1}) begin
        n_errors++;
        $display("FAIL reset_state[%0d]: got out=%b ov=%b busy=%b cnt=%0d rdy=%b want 0000 0 0 0 1",
                 k, out[k], out_valid[k], busy[k], count[k], in_ready[k]);
      end
      n_checks++;
      if (ovf[k] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_overflow[%0d]: got %b want 0", k, ovf[k]);
      end
    end
  endtask

  task automatic test_single;
    logic [3:0] exp_out  [5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic       exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    cyc(1'b0, 1'b1, 2'b10);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc(1'b0, 1'b0, 2'b00);
      n_checks++;
      if (out[0] !== exp_out[i] || out_valid[0] !== (exp_out[i] != 4'b0000)) begin
        n_errors++;
        $display("FAIL single_out[E%0d]: got %b/%b want %b", i, out[0], out_valid[0], exp_out[i]);
      end
      n_checks++;
      if (busy[0] !== exp_busy[i]) begin
        n_errors++;
        $display("FAIL single_busy[E%0d]: got %b want %b", i, busy[0], exp_busy[i]);
      end
    end
    drain(12);
  endtask

  task automatic test_burst;
    logic [3:0] tbl [12] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                             4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    cyc(1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, i < 3, 2'(i + 1));
      n_checks++;
      if (out[0] !== tbl[i]) begin
        n_errors++;
        $display("FAIL burst_out[%0d]: got %b want %b", i, out[0], tbl[i]);
      end
      n_checks++;
      if (count[0] > 3'd4) begin
        n_errors++;
        $display("FAIL burst_count[%0d]: got %0d want <=4", i, count[0]);
      end
    end
    drain(40);
  endtask

  task automatic test_gap0;
    logic [3:0] tbl [5] = '{4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0000};
    cyc(1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, i == 0, 2'd0);
      n_checks++;
      if (out[1] !== tbl[i]) begin
        n_errors++;
        $display("FAIL gap0_out[%0d]: got %b want %b", i, out[1], tbl[i]);
      end
    end
    drain(20);
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 2'(i + 1));
      if (i >= 4) begin
        n_checks++;
        if (count[2] !== 3'd4 || in_ready[2] !== 1'b0) begin
          n_errors++;
          $display("FAIL fill_full[E%0d]: got cnt=%0d rdy=%b want 4 0", i, count[2], in_ready[2]);
        end
      end
    end
`ifdef DEC_OVERFLOW_FLAG_EN
    n_checks++;
    if (ovf[2] !== 1'b1 || ovf[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL fill_overflow: got hold8=%b def=%b want 1 0", ovf[2], ovf[0]);
    end
`endif
    for (int c = 0; c < 50; c++) begin
      cyc(1'b0, 1'b0, 2'b00);
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (out[k] !== m_out(k) || count[k] !== 3'(m_cnt[k])) begin
          n_errors++;
          $display("FAIL fill_drain[%0d] c=%0d: got out=%b cnt=%0d want %b %0d",
                   k, c, out[k], count[k], m_out(k), m_cnt[k]);
        end
      end
`ifdef DEC_OVERFLOW_FLAG_EN
      n_checks++;
      if (ovf[2] !== 1'b1) begin
        n_errors++;
        $display("FAIL overflow_sticky c=%0d: got %b want 1", c, ovf[2]);
      end
`endif
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] codes [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, codes[i]);
    n_checks++;
    if (out[0] !== 4'b0010 || count[0] !== 3'd3) begin
      n_errors++;
      $display("FAIL midreset_pre: got out=%b cnt=%0d want 0010 3", out[0], count[0]);
    end
    cyc(1'b1, 1'b0, 2'b00);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({out[k], out_valid[k], busy[k], count[k], in_ready[k], ovf[k]} !== {4'b0000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL midreset_post[%0d]: got out=%b ov=%b busy=%b cnt=%0d rdy=%b ovf=%b",
                 k, out[k], out_valid[k], busy[k], count[k], in_ready[k], ovf[k]);
      end
    end
    for (int c = 0; c < 12; c++) begin
      cyc(1'b0, 1'b0, 2'b00);
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (out[k] !== 4'b0000) begin
          n_errors++;
          $display("FAIL midreset_quiet[%0d] c=%0d: got %b want 0000", k, c, out[k]);
        end
      end
    end
  endtask

  task automatic test_random;
    logic       v;
    logic       r;
    logic [1:0] c;
    for (int n = 0; n < 800; n++) begin
      v = ($urandom_range(0, 9) < ((n < 400) ? 8 : 4));
      r = ($urandom_range(0, 149) == 0);
      c = 2'($urandom_range(0, 3));
      cyc(r, v, c);
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if ({out[k], out_valid[k], busy[k], count[k], in_ready[k]} !==
            {m_out(k), m_out(k) != 4'b0000, m_busy(k), 3'(m_cnt[k]), m_cnt[k] < DEPTH}) begin
          n_errors++;
          $display("FAIL random[%0d] n=%0d: got out=%b ov=%b busy=%b cnt=%0d rdy=%b want out=%b busy=%b cnt=%0d",
                   k, n, out[k], out_valid[k], busy[k], count[k], in_ready[k], m_out(k), m_busy(k), m_cnt[k]);
        end
`ifdef DEC_OVERFLOW_FLAG_EN
        n_checks++;
        if (ovf[k] !== m_ovf[k]) begin
          n_errors++;
          $display("FAIL random_overflow[%0d] n=%0d: got %b want %b", k, n, ovf[k], m_ovf[k]);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_gap0;
    test_fill_overflow;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
